master_memory_burst: RTL

Parametrised burst-capable local memory for bus masters, successor to the single-beat master memory. Accepts one command at a time over a valid/ready command channel, then streams the burst's data: write data in, or read data out with backpressure. Supports byte-lane write strobes, incrementing or fixed addressing, and address wrap at the memory top. It sits between a master's internal sequencing logic and its local block RAM, which must still infer as M9K.

---
 rtl/master_memory_burst_if.sv | 36 +++
 rtl/master_memory_burst.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/master_memory_burst_if.sv
// Command, write-beat and read-beat channels between a bus master and its burst memory.
interface master_memory_burst_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic                  cmd_fixed;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  busy;

    modport master (
        output cmd_valid, cmd_write, cmd_fixed, cmd_addr, cmd_len,
        output wr_valid, wr_data, wr_strb, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_fixed, cmd_addr, cmd_len,
        input  wr_valid, wr_data, wr_strb, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy
    );
endinterface

// File: rtl/master_memory_burst.sv
// Burst-capable local block RAM for a bus master: one command at a time, byte-strobed
// write bursts, and backpressured read bursts through a 2-entry output FIFO.
module master_memory_burst #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 4096,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    master_memory_burst_if.slave bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int MEM_AW     = $clog2(MEM_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [1:0]           state_q, state_d;
    logic                 up_q;
    logic [MEM_AW-1:0]    addr_q, addr_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 fixed_q, fixed_d;
    logic                 issue_done_q, issue_done_d;

    logic                  ram_vld_q;
    logic                  ram_last_q;
    logic [DATA_WIDTH-1:0] ram_data_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [1:0]            fifo_last_q;
    logic                  fifo_rptr_q;
    logic                  fifo_wptr_q;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

    logic       cmd_ready;
    logic       rd_valid;
    logic       cmd_fire;
    logic       wr_fire;
    logic       rd_pop;
    logic       rd_issue;
    logic       rd_finish;
    logic [2:0] occ;

    function automatic logic [MEM_AW-1:0] next_addr(input logic [MEM_AW-1:0] a,
                                                    input logic fixed);
        return fixed ? a : a + MEM_AW'(1);
    endfunction

    assign cmd_ready = up_q && (state_q == ST_IDLE);
    assign rd_valid  = (fifo_cnt_q != 2'd0);
    assign cmd_fire  = bus.cmd_valid && cmd_ready;
    assign wr_fire   = bus.wr_valid && (state_q == ST_WRITE);
    assign rd_pop    = rd_valid && bus.rd_ready && (state_q == ST_READ);
    assign rd_finish = rd_pop && fifo_last_q[fifo_rptr_q];

    // Occupancy counts the FIFO plus the read in the RAM output register; a pop this
    // cycle frees a slot so the stream keeps full rate without bubbles.
    assign occ      = {1'b0, fifo_cnt_q} + {2'b00, ram_vld_q};
    assign rd_issue = (state_q == ST_READ) && !issue_done_q &&
                      (occ < (rd_pop ? 3'd3 : 3'd2));

    assign fifo_cnt_d = fifo_cnt_q + {1'b0, ram_vld_q} - {1'b0, rd_pop};

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        fixed_d      = fixed_q;
        issue_done_d = issue_done_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d      = bus.cmd_write ? ST_WRITE : ST_READ;
                    addr_d       = bus.cmd_addr[MEM_AW-1:0];
                    rem_d        = bus.cmd_len;
                    fixed_d      = bus.cmd_fixed;
                    issue_done_d = 1'b0;
                end
            end
            ST_WRITE: begin
                if (wr_fire) begin
                    if (rem_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        rem_d  = rem_q - LEN_WIDTH'(1);
                        addr_d = next_addr(addr_q, fixed_q);
                    end
                end
            end
            ST_READ: begin
                if (rd_issue) begin
                    if (rem_q == '0) begin
                        issue_done_d = 1'b1;
                    end else begin
                        rem_d  = rem_q - LEN_WIDTH'(1);
                        addr_d = next_addr(addr_q, fixed_q);
                    end
                end
                if (rd_finish) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            up_q         <= 1'b0;
            addr_q       <= '0;
            rem_q        <= '0;
            fixed_q      <= 1'b0;
            issue_done_q <= 1'b1;
            ram_vld_q    <= 1'b0;
            ram_last_q   <= 1'b0;
            fifo_last_q  <= '0;
            fifo_rptr_q  <= 1'b0;
            fifo_wptr_q  <= 1'b0;
            fifo_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            up_q         <= 1'b1;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            fixed_q      <= fixed_d;
            issue_done_q <= issue_done_d;
            ram_vld_q    <= rd_issue;
            if (rd_issue) begin
                ram_last_q <= (rem_q == '0);
            end
            if (ram_vld_q) begin
                fifo_last_q[fifo_wptr_q] <= ram_last_q;
                fifo_wptr_q              <= ~fifo_wptr_q;
            end
            if (rd_pop) begin
                fifo_rptr_q <= ~fifo_rptr_q;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // RAM array and data path carry no reset so the array still maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (bus.wr_strb[i]) begin
                    mem[addr_q][8*i +: 8] <= bus.wr_data[8*i +: 8];
                end
            end
        end
        if (rd_issue) begin
            ram_data_q <= mem[addr_q];
        end
        if (ram_vld_q) begin
            fifo_data_q[fifo_wptr_q] <= ram_data_q;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.wr_ready  = (state_q == ST_WRITE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_data   = rd_valid ? fifo_data_q[fifo_rptr_q] : '0;
    assign bus.rd_last   = rd_valid && fifo_last_q[fifo_rptr_q];
endmodule
